// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-phase data-memory access sequencer with req/ack handshake
`timescale 1ns/1ps
module mem_access_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [5:0]  opcode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err_adel,
  output logic        err_ades,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [29:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       size_q;
  logic             signed_q;
  logic [1:0]       lane_q;

  logic        legal, is_load, is_signed, aligned;
  logic [1:0]  size_c;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] load_ext;

  assign busy = (state != IDLE);

  // Decode of the incoming request, only consumed in IDLE when start is sampled.
  always_comb begin
    legal     = 1'b1;
    is_load   = 1'b0;
    is_signed = 1'b0;
    size_c    = SZ_WORD;
    case (opcode)
      6'h23: is_load = 1'b1;
      6'h20: begin is_load = 1'b1; is_signed = 1'b1; size_c = SZ_BYTE; end
      6'h24: begin is_load = 1'b1; size_c = SZ_BYTE; end
      6'h21: begin is_load = 1'b1; is_signed = 1'b1; size_c = SZ_HALF; end
      6'h25: begin is_load = 1'b1; size_c = SZ_HALF; end
      6'h2b: size_c = SZ_WORD;
      6'h28: size_c = SZ_BYTE;
      6'h29: size_c = SZ_HALF;
      default: legal = 1'b0;
    endcase

    case (size_c)
      SZ_WORD: begin
        aligned = (addr[1:0] == 2'b00);
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
      SZ_HALF: begin
        aligned = ~addr[0];
        be_c    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        aligned = 1'b1;
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
    endcase
  end

  always_comb begin
    byte_v = mem_rdata[8*lane_q +: 8];
    half_v = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_WORD: load_ext = mem_rdata;
      SZ_HALF: load_ext = {{16{signed_q & half_v[15]}}, half_v};
      default: load_ext = {{24{signed_q & byte_v[7]}}, byte_v};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      size_q    <= SZ_BYTE;
      signed_q  <= 1'b0;
      lane_q    <= 2'b00;
      done      <= 1'b0;
      err_adel  <= 1'b0;
      err_ades  <= 1'b0;
      rdata     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      done     <= 1'b0;
      err_adel <= 1'b0;
      err_ades <= 1'b0;
      case (state)
        IDLE: if (start) begin
          size_q    <= size_c;
          signed_q  <= is_signed;
          lane_q    <= addr[1:0];
          count     <= '0;
          mem_addr  <= addr[31:2];
          mem_wdata <= wdata_c;
          mem_be    <= be_c;
          mem_we    <= ~is_load;
          if (legal && aligned) begin
            state   <= REQ;
            mem_req <= 1'b1;
          end else begin
            // Illegal opcodes report on the store-side flag.
            state    <= ERR;
            done     <= 1'b1;
            err_adel <= legal & is_load;
            err_ades <= ~(legal & is_load);
          end
        end
        REQ: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= 1'b1;
            if (!mem_we) rdata <= load_ext;
          end else if (count == CNT_W'(TIMEOUT - 1)) begin
            state    <= ERR;
            mem_req  <= 1'b0;
            done     <= 1'b1;
            err_adel <= ~mem_we;
            err_ades <= mem_we;
          end else begin
            count <= count + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - directed and randomized bench for mem_access_ctrl against a behavioural model
`timescale 1ns/1ps
module tb_mem_access_ctrl;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        busy, done, err_adel, err_ades;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int failures = 0;
  logic [31:0] rdata_model = '0;

  localparam logic [5:0] OP_LW = 6'h23, OP_LB = 6'h20, OP_LBU = 6'h24, OP_LH = 6'h21,
                         OP_LHU = 6'h25, OP_SW = 6'h2b, OP_SB = 6'h28, OP_SH = 6'h29;

  mem_access_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err_adel(err_adel), .err_ades(err_ades), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Access size in bytes (0 = illegal), direction and signedness from the opcode.
  task automatic decode(input logic [5:0] op, output int size, output bit ld, output bit sg);
    size = 0; ld = 0; sg = 0;
    case (op)
      OP_LW:  begin size = 4; ld = 1; end
      OP_LB:  begin size = 1; ld = 1; sg = 1; end
      OP_LBU: begin size = 1; ld = 1; end
      OP_LH:  begin size = 2; ld = 1; sg = 1; end
      OP_LHU: begin size = 2; ld = 1; end
      OP_SW:  size = 4;
      OP_SB:  size = 1;
      OP_SH:  size = 2;
      default: size = 0;
    endcase
  endtask

  function automatic logic [31:0] load_val(int size, bit sg, logic [31:0] a, logic [31:0] w);
    logic [31:0] v;
    v = w >> (8 * a[1:0]);
    if (size == 4) return w;
    if (size == 2) return sg ? 32'($signed(v[15:0])) : {16'h0, v[15:0]};
    return sg ? 32'($signed(v[7:0])) : {24'h0, v[7:0]};
  endfunction

  function automatic logic [31:0] store_val(int size, logic [31:0] w);
    if (size == 4) return w;
    if (size == 2) return {w[15:0], w[15:0]};
    return {w[7:0], w[7:0], w[7:0], w[7:0]};
  endfunction

  // delay = REQ cycle in which ack is raised; delay 0 = never ack (timeout).
  task automatic access(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                        input int delay, input logic [31:0] mrd, input bit spam);
    int size, n;
    bit ld, sg, is_err;
    logic [3:0] be_exp;
    decode(op, size, ld, sg);
    is_err = (size == 0) || ((a % size) != 0);
    be_exp = (size == 0) ? 4'h0 : 4'(((1 << size) - 1) << a[1:0]);
    @(negedge clk);
    start = 1'b1; opcode = op; addr = a; wdata = wd;
    @(negedge clk);
    start = 1'b0; opcode = 6'($urandom); addr = $urandom; wdata = $urandom;
    chk("busy_after_start", busy, 1);
    if (is_err) begin
      chk("err_no_req", mem_req, 0);
      chk("err_done", done, 1);
      chk("err_adel", err_adel, (size != 0) && ld);
      chk("err_ades", err_ades, !((size != 0) && ld));
      chk("err_rdata_held", rdata, rdata_model);
    end else begin
      chk("req", mem_req, 1);
      chk("we", mem_we, !ld);
      chk("be", mem_be, be_exp);
      chk("maddr", mem_addr, a >> 2);
      if (!ld) chk("mwdata", mem_wdata, store_val(size, wd));
      if (delay == 0) begin
        n = 0;
        while (mem_req === 1'b1 && n < 100) begin
          n++;
          start = spam && (n % 3 == 1);
          opcode = OP_LW; addr = 32'h0;
          @(negedge clk);
        end
        start = 1'b0;
        chk("timeout_req_cycles", n, TIMEOUT);
        chk("timeout_done", done, 1);
        chk("timeout_adel", err_adel, ld);
        chk("timeout_ades", err_ades, !ld);
        chk("timeout_rdata_held", rdata, rdata_model);
      end else begin
        n = 1;
        while (n < delay) begin
          @(negedge clk);
          n++;
          chk("req_held", mem_req, 1);
          chk("be_held", mem_be, be_exp);
        end
        mem_ack = 1'b1; mem_rdata = mrd;
        @(negedge clk);
        mem_ack = 1'b0; mem_rdata = $urandom;
        chk("ok_done", done, 1);
        chk("ok_errs", {err_adel, err_ades}, 0);
        chk("ok_req_low", mem_req, 0);
        if (ld) rdata_model = load_val(size, sg, a, mrd);
        chk("rdata", rdata, rdata_model);
      end
    end
    @(negedge clk);
    chk("done_pulse_end", done, 0);
    chk("idle", busy, 0);
  endtask

  logic [5:0] ops [9] = '{OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_SW, OP_SB, OP_SH, 6'h3f};

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_errs", {err_adel, err_ades}, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_maddr", mem_addr, 0);
    chk("rst_mwdata", mem_wdata, 0);
    rst = 1'b1;

    access(OP_LW, 32'h100, 32'h0, 3, 32'hDEADBEEF, 0);
    chk("lw_const", rdata, 32'hDEADBEEF);
    access(OP_LB, 32'h103, 32'h0, 1, 32'h80FF0011, 0);
    chk("lb_const", rdata, 32'hFFFFFF80);
    access(OP_LBU, 32'h103, 32'h0, 2, 32'h80FF0011, 0);
    chk("lbu_const", rdata, 32'h00000080);
    access(OP_SH, 32'h22, 32'h0000ABCD, 2, 32'h0, 0);
    access(OP_LW, 32'h102, 32'h0, 1, 32'h0, 0);
    access(OP_SH, 32'h101, 32'h1234, 1, 32'h0, 0);
    access(OP_LH, 32'h4, 32'h0, 0, 32'h0, 1);
    access(OP_SW, 32'h8, 32'h11223344, 0, 32'h0, 0);

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    start = 1'b1; opcode = OP_SW; addr = 32'h40; wdata = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_req", mem_req, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_req_drop", mem_req, 0);
    chk("async_busy_drop", busy, 0);
    @(negedge clk);
    rst = 1'b1;
    rdata_model = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_done_after_rst", done, 0);
    end
    access(OP_SW, 32'h44, 32'h5A5A1234, 2, 32'h0, 0);

    for (int i = 0; i < 40; i++) begin
      access(ops[$urandom_range(0, 8)], $urandom, $urandom, $urandom_range(1, 4), $urandom, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
